// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller_pkg
// Brief    : Shared tags, forward codes and shadow-stage type for the hazard
//            controller of the 16-bit five-stage core.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_controller_pkg;

    localparam int TAG_WIDTH = 4;

    localparam logic [TAG_WIDTH-1:0] TAG_NONE = 4'hF;
    localparam logic [TAG_WIDTH-1:0] TAG_IH   = 4'h8;
    localparam logic [TAG_WIDTH-1:0] TAG_SP   = 4'h9;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic                 isLoad;
        logic                 isStore;
        logic                 writesT;
        logic                 valid;
    } stage_t;

    function automatic stage_t stage_bubble();
        stage_t s;
        s.tag     = TAG_NONE;
        s.isLoad  = 1'b0;
        s.isStore = 1'b0;
        s.writesT = 1'b0;
        s.valid   = 1'b0;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_controller_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Brief    : Compares one ID source tag (and the T-flag read) against one
//            shadow pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_controller_pkg::*;
(
    input  logic [TAG_WIDTH-1:0] src_tag_i,
    input  logic                 src_use_i,
    input  logic                 reads_t_i,
    input  stage_t               stage_i,
    output logic                 reg_match_o,
    output logic                 t_match_o
);

    // Tag F marks "no destination" and must never alias a real source.
    assign reg_match_o = src_use_i && stage_i.valid &&
                         (stage_i.tag == src_tag_i) &&
                         (stage_i.tag != TAG_NONE);

    assign t_match_o   = reads_t_i && stage_i.valid && stage_i.writesT;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Stall / bubble / flush / forwarding control from an EX+MEM shadow
//            pipeline. Optional forwarding: define HAZARD_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int TAG_W = TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] id_registerX,
    input  logic [TAG_W-1:0] id_registerY,
    input  logic [TAG_W-1:0] id_registerZ,
    input  logic             id_useX,
    input  logic             id_useY,
    input  logic             id_isLoad,
    input  logic             id_isStore,
    input  logic             id_readsT,
    input  logic             id_writesT,
    input  logic             ex_branchTaken,
    input  logic             freeze,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       forwardX,
    output logic [1:0]       forwardY
);

    stage_t ex_q, mem_q, ex_d;
    stage_t w_stage [2];

    logic [1:0] w_mx, w_my, w_tx, w_ty;
    logic       w_t_any, w_raw, w_struct;
    fwd_e       w_fx, w_fy;

    assign w_stage[0] = ex_q;
    assign w_stage[1] = mem_q;

    // Index 0 = EX stage, index 1 = MEM stage.
    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_stage
            hazard_match u_match_x (
                .src_tag_i   (id_registerX),
                .src_use_i   (id_useX),
                .reads_t_i   (id_readsT),
                .stage_i     (w_stage[s]),
                .reg_match_o (w_mx[s]),
                .t_match_o   (w_tx[s])
            );
            hazard_match u_match_y (
                .src_tag_i   (id_registerY),
                .src_use_i   (id_useY),
                .reads_t_i   (id_readsT),
                .stage_i     (w_stage[s]),
                .reg_match_o (w_my[s]),
                .t_match_o   (w_ty[s])
            );
        end
    endgenerate

    // T is never forwarded, so any in-flight writer of T stalls a reader.
    assign w_t_any  = (|w_tx) | (|w_ty);
    assign w_struct = mem_q.isLoad | mem_q.isStore;

`ifdef HAZARD_FORWARDING_EN
    function automatic fwd_e fwd_code(input logic ex_m, input logic mem_m,
                                      input logic ex_load);
        if (ex_m && !ex_load) return FWD_EXMEM;
        if (mem_m)            return FWD_MEMWB;
        return FWD_RF;
    endfunction

    assign w_raw = ((w_mx[0] | w_my[0]) & ex_q.isLoad) | w_t_any;
    assign w_fx  = fwd_code(w_mx[0], w_mx[1], ex_q.isLoad);
    assign w_fy  = fwd_code(w_my[0], w_my[1], ex_q.isLoad);
`else
    assign w_raw = (|w_mx) | (|w_my) | w_t_any;
    assign w_fx  = FWD_RF;
    assign w_fy  = FWD_RF;
`endif

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        forwardX    = FWD_RF;
        forwardY    = FWD_RF;
        if (rst) begin
            if (freeze) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else if (ex_branchTaken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_raw) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                // A RAM conflict loses the fetch but the ID instruction still issues.
                if (w_struct) begin
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                end
                forwardX = w_fx;
                forwardY = w_fy;
            end
        end
    end

    always_comb begin
        ex_d = stage_bubble();
        if (!idex_bubble) begin
            ex_d.tag     = id_registerZ;
            ex_d.isLoad  = id_isLoad;
            ex_d.isStore = id_isStore;
            ex_d.writesT = id_writesT;
            ex_d.valid   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= stage_bubble();
            mem_q <= stage_bubble();
        end else if (!freeze) begin
            mem_q <= ex_q;
            ex_q  <= ex_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Directed self-checking bench for hazard_controller; expectations
//            adapt to whether HAZARD_FORWARDING_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, forwardX, forwardY}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] STALL  = 8'b1101_0000;
    localparam logic [7:0] STRUCT = 8'b1010_0000;
    localparam logic [7:0] BRANCH = 8'b0011_0000;
    localparam logic [7:0] FRZ    = 8'b1100_0000;
    localparam logic [7:0] FX1    = 8'b0000_0100;
    localparam logic [7:0] FX2    = 8'b0000_1000;
    localparam logic [7:0] FY2    = 8'b0000_0010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rX, rY, rZ;
    logic       uX, uY, ld, st, rT, wT;
    logic       br  = 1'b0;
    logic       frz = 1'b0;

    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic [1:0] forwardX, forwardY;
    logic [7:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk            (clk),
        .rst            (rst),
        .id_registerX   (rX),
        .id_registerY   (rY),
        .id_registerZ   (rZ),
        .id_useX        (uX),
        .id_useY        (uY),
        .id_isLoad      (ld),
        .id_isStore     (st),
        .id_readsT      (rT),
        .id_writesT     (wT),
        .ex_branchTaken (br),
        .freeze         (frz),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .forwardX       (forwardX),
        .forwardY       (forwardY)
    );

    assign obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, forwardX, forwardY};

    task automatic set_id(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                          input logic ux, input logic uy, input logic l, input logic s,
                          input logic rt, input logic wt);
        rX = x; rY = y; rZ = z;
        uX = ux; uY = uy; ld = l; st = s; rT = rt; wT = wt;
    endtask

    task automatic idle();
        set_id(4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        #1;
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset dominates freeze, branch and a would-be match.
        set_id(4'h3, 4'h3, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        frz = 1'b1; br = 1'b1;
        chk("reset_outputs", NONE);
        tick(); tick();
        rst = 1'b1; frz = 1'b0; br = 1'b0;
        idle();
        chk("after_reset_idle", NONE);

        // addiu R3 then addu X=3 (Y=3 unused)
        set_id(4'h1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addiu_issue", NONE);
        tick();
        set_id(4'h3, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("raw_ex_producer", FWD ? FX1 : STALL);
        tick();
        chk("raw_mem_producer", FWD ? FX2 : STALL);
        tick();
        chk("raw_resolved", NONE);
        tick();

        // Matching tags with use bits low; then tag F exclusion and a Y match in MEM
        set_id(4'h4, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("use_bits_low", NONE);
        tick();
        set_id(4'hF, 4'h4, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tagF_and_memY", FWD ? FY2 : STALL);
        tick();

        // Load-use: lw R2 then sw with X=2
        set_id(4'h1, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lw_issue", NONE);
        tick();
        set_id(4'h2, 4'h5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("load_use_stall", STALL);
        tick();
        chk("load_in_mem", FWD ? (STRUCT | FX2) : STALL);
        tick();
        idle();
        chk("drain_1", NONE);
        tick();
        chk("drain_2_store_in_mem", FWD ? STRUCT : NONE);
        tick();

        // Structural conflict alone
        set_id(4'hF, 4'hF, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("struct_lw_issue", NONE);
        tick();
        set_id(4'h1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("struct_lw_in_ex", NONE);
        tick();
        chk("struct_conflict", STRUCT);
        tick();

        // Taken branch while a RAW on SP is pending
        set_id(4'hF, 4'hF, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("move_sp_issue", NONE);
        tick();
        set_id(4'h9, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        br = 1'b1;
        chk("branch_over_raw", BRANCH);
        tick();
        br = 1'b0;
        idle();
        chk("after_branch", NONE);
        tick();

        // move SP then addsp X=9
        set_id(4'hF, 4'hF, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sp_producer", NONE);
        tick();
        set_id(4'h9, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sp_cycle1", FWD ? FX1 : STALL);
        tick();
        chk("sp_cycle2", FWD ? FX2 : STALL);
        tick();
        chk("sp_done", NONE);
        tick();

        // cmp writes T, bteqz reads T: stalls in both builds
        set_id(4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cmp_issue", NONE);
        tick();
        set_id(4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t_in_ex", STALL);
        tick();
        chk("t_in_mem", STALL);
        tick();
        chk("t_done", NONE);
        tick();

        // Freeze holds shadow state and suppresses the bubble
        set_id(4'hF, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("move_r5_issue", NONE);
        tick();
        set_id(4'h5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frz = 1'b1;
        chk("freeze", FRZ);
        tick();
        frz = 1'b0;
        chk("after_freeze_ex_held", FWD ? FX1 : STALL);
        tick();

        // Asynchronous reset in the middle of a hazard
        chk("pre_reset_mem_match", FWD ? FX2 : STALL);
        rst = 1'b0;
        chk("reset_mid_op", NONE);
        tick();
        rst = 1'b1;
        idle();
        chk("reset_release_idle", NONE);
        set_id(4'h5, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("shadow_cleared", NONE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control block for the 16-bit five-stage core (IF, ID, EX, MEM, WB). It keeps a shadow pipeline of destination tags for the instructions in EX and MEM and compares them with the source tags produced by the instruction decoder in ID. From that it generates stall, bubble, flush and forwarding controls. It also resolves the structural conflict on the shared instruction/data RAM and applies the flush on a taken branch or jump.

## Interface
Parameters:
- TAG_W, 4, register tag width; tag 4'hF means "no destination"; 8 = IH, 9 = SP.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- id_registerX  in  4  first source tag of the instruction in ID.
- id_registerY  in  4  second source tag of the instruction in ID.
- id_registerZ  in  4  destination tag of the instruction in ID (4'hF = none).
- id_useX, id_useY  in  1 each  source tag is actually read; when low, that tag is never compared.
- id_isLoad, id_isStore  in  1 each  the ID instruction accesses data memory.
- id_readsT, id_writesT  in  1 each  the ID instruction reads or writes the T flag.
- ex_branchTaken  in  1  branch or jump resolved taken in EX this cycle.
- freeze  in  1  external wait request; holds the whole pipeline.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  load a nop into IF/ID.
- idex_bubble  out  1  load a nop into ID/EX.
- forwardX, forwardY  out  2 each  operand source for the instruction leaving ID: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.

## Operation
- Shadow stages ex_* and mem_* each hold: tag, isLoad, isStore, writesT, valid.
- Each posedge, with no freeze:
  - mem_* takes ex_*.
  - ex_* takes the ID fields, or a bubble (tag F, all flags 0) when idex_bubble = 1.
- With freeze = 1, the shadow stages hold their contents.
- A source matches a producer when its use bit is 1, the producer is valid, and the producer tag equals the source tag and is not F. The T flag matches when id_readsT = 1 and the producer has writesT = 1.
- RAW stall, with forwarding compiled in: a match on an EX-stage load.
- RAW stall, without forwarding: any match in EX or MEM.
- A stall drives pc_stall = 1, ifid_stall = 1, idex_bubble = 1.
- Structural conflict: mem_isLoad or mem_isStore is 1, so the RAM is busy and no fetch occurs. Drives pc_stall = 1, ifid_flush = 1.
- Taken branch: ex_branchTaken = 1 drives ifid_flush = 1, idex_bubble = 1, pc_stall = 0 so the PC loads the target.
- Priority, highest first:
  - freeze: only pc_stall = 1 and ifid_stall = 1; no bubbles.
  - branch flush: overrides both stalls because the ID instruction is killed.
  - RAW stall: when a RAW stall and a structural conflict occur together, the RAW outputs win. IF/ID holds and is not flushed.
  - structural conflict.
- The T flag is not forwarded in either configuration. A T match in EX or MEM always stalls.
- Forward code for a source: 1 if it matches a non-load EX producer; otherwise 2 if it matches a MEM producer; otherwise 0. An EX match takes precedence over a MEM match (youngest producer wins).
- During a stall the forward codes are don't-care; the bench treats them as 0.
- A WB-stage producer never creates a hazard, because the register file writes before it is read.

## Timing
- All outputs are combinational from the shadow state and the ID inputs, and are registered by the datapath on the next posedge.
- Reset:
  - While rst = 0, every output is 0 and the shadow stages are cleared asynchronously (tag F, flags 0).
  - If rst is asserted mid-operation, the shadow stages clear the same way; no stall persists after rst is released.
- Load-use with forwarding: exactly 1 stall cycle, then forward code 2.
- RAW without forwarding: 2 stall cycles for an EX producer, 1 stall cycle for a MEM producer.
- Taken branch: 2 bubbles (the IF and ID slots), applied in the same cycle as ex_branchTaken.
- Structural conflict: 1 fetch slot lost per memory access.

## Configuration
- HAZARD_FORWARDING_EN defined:
  - forwarding logic is built;
  - the only register RAW stall is load-use (1 cycle).
- HAZARD_FORWARDING_EN undefined:
  - forwardX and forwardY are tied to 0;
  - any EX or MEM match stalls until the producer reaches WB.

## Structure
- The shared package holds:
  - TAG_NONE = 4'hF, TAG_IH = 4'h8, TAG_SP = 4'h9;
  - forward codes FWD_RF, FWD_EXMEM, FWD_MEMWB;
  - the shadow-stage struct (tag, isLoad, isStore, writesT, valid).
- One sub-module, hazard_match: tag and flag comparator for one source against one stage, instantiated per source and stage.

## Test plan
- Forwarding on; addiu R3 in EX (Z = 3), then addu in ID with X = 3, useX = 1 -> no stall, forwardX = 1. Same producer in MEM -> forwardX = 2.
- Forwarding on; lw in EX (Z = 2, isLoad = 1), sw in ID with X = 2 -> one cycle of pc_stall = ifid_stall = idex_bubble = 1, then forwardX = 2.
- Forwarding off; move Z = 9 (SP), then addsp with X = 9 -> 2 stall cycles, then forwardX = 0.
- lw in MEM with the RAW stall of the previous case active -> ifid_stall = 1, ifid_flush = 0. lw in MEM and no RAW -> pc_stall = 1, ifid_flush = 1.
- ex_branchTaken = 1 while a RAW stall is pending -> ifid_flush = 1, idex_bubble = 1, pc_stall = 0.
- cmp (writesT) in EX, bteqz (readsT) in ID -> stall in both configurations.
- rst pulled low mid-stall -> all outputs 0; after release with idle ID inputs, no stall.
